// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns a beat
//   mem_cmd_t   : one memory command (store flag, address, store data, funct3)
//   F3_*        : access size/sign encodings shared with the data memory
// Command fields are sized for the widest supported bus (32 bits); the
// arbiter zero-extends narrower AW/DW configurations into them.
package dmem_arb_pkg;

  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    CORE,
    DMA,
    DMA_LOCKED
  } arb_state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_DMA
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [2:0]        funct3;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arb_cmd_reg.sv
// Registered command and read-return stage of the data-memory arbiter.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cmd_vld, cmd, owner  winning beat of the current cycle and its owner
//   mem_read/mem_write   one-cycle command strobes (cycle after acceptance)
//   mem_addr/wdata/funct3 registered command fields
//   mem_rdata            combinational read data from the memory
//   core_rvalid/rdata    load return to the core (two cycles after acceptance)
//   dma_rvalid/rdata     load return to the DMA side
module dmem_arb_cmd_reg
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  input  mem_cmd_t      cmd,
  input  owner_e        owner,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata
);

  logic          rd_vld_p1;
  logic          wr_vld_p1;
  mem_cmd_t      cmd_p1;
  owner_e        own_p1;
  logic          core_vld_p2;
  logic          dma_vld_p2;
  logic [DW-1:0] core_data_p2;
  logic [DW-1:0] dma_data_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_p1    <= 1'b0;
      wr_vld_p1    <= 1'b0;
      cmd_p1       <= '0;
      own_p1       <= OWN_CORE;
      core_vld_p2  <= 1'b0;
      dma_vld_p2   <= 1'b0;
      core_data_p2 <= '0;
      dma_data_p2  <= '0;
    end else begin
      // p0 -> p1: register the accepted command; strobes last one cycle
      rd_vld_p1 <= cmd_vld & ~cmd.we;
      wr_vld_p1 <= cmd_vld & cmd.we;
      if (cmd_vld) begin
        cmd_p1 <= cmd;
        own_p1 <= owner;
      end
      // p1 -> p2: capture load data for the owner; data holds when no load
      core_vld_p2 <= rd_vld_p1 & (own_p1 == OWN_CORE);
      dma_vld_p2  <= rd_vld_p1 & (own_p1 == OWN_DMA);
      if (rd_vld_p1 && own_p1 == OWN_CORE) core_data_p2 <= mem_rdata;
      if (rd_vld_p1 && own_p1 == OWN_DMA)  dma_data_p2  <= mem_rdata;
    end
  end

  assign mem_read    = rd_vld_p1;
  assign mem_write   = wr_vld_p1;
  assign mem_addr    = cmd_p1.addr[AW-1:0];
  assign mem_wdata   = cmd_p1.wdata[DW-1:0];
  assign mem_funct3  = cmd_p1.funct3;
  assign core_rvalid = core_vld_p2;
  assign core_rdata  = core_data_p2;
  assign dma_rvalid  = dma_vld_p2;
  assign dma_rdata   = dma_data_p2;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and a DMA/loader.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   core_req/we/addr/wdata/funct3   core command, held until core_gnt
//   core_gnt, core_stall            accept strobe, stall = req & ~gnt
//   core_rvalid/rdata               core load return
//   dma_req/we/addr/wdata/funct3    DMA command, held until dma_gnt
//   dma_lock                        keep the port on DMA for back-to-back beats
//   dma_gnt, dma_rvalid/rdata       DMA accept strobe and load return
//   mem_read/write/addr/wdata/funct3 registered memory command
//   mem_rdata                       combinational memory read data
// Optional feature: define DMEM_ARB_STATS_EN to add the 32-bit counters
//   stat_core_beats, stat_dma_beats, stat_conflicts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [2:0]    core_funct3,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [2:0]    dma_funct3,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_core_beats,
  output logic [31:0]   stat_dma_beats,
  output logic [31:0]   stat_conflicts
`endif
);

  localparam int             WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

  arb_state_e     state;
  owner_e         last_owner;
  logic [WCW-1:0] wait_cnt;
  logic           lock_hold;
  logic           force_core;
  logic           cmd_vld;
  owner_e         owner;
  mem_cmd_t       cmd;

  // Lock only binds while DMA keeps both req and lock up; the core is
  // forced through once it has waited MAX_WAIT cycles.
  assign lock_hold  = (state == DMA_LOCKED) & dma_req & dma_lock;
  assign force_core = lock_hold & core_req & (wait_cnt == WAIT_LIM);

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (lock_hold) begin
      core_gnt = force_core;
      dma_gnt  = ~force_core;
    end else if (core_req && dma_req) begin
      core_gnt = (last_owner == OWN_DMA);
      dma_gnt  = (last_owner == OWN_CORE);
    end else begin
      core_gnt = core_req;
      dma_gnt  = dma_req;
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign cmd_vld    = core_gnt | dma_gnt;
  assign owner      = core_gnt ? OWN_CORE : OWN_DMA;

  always_comb begin
    cmd = '0;
    if (core_gnt) begin
      cmd.we     = core_we;
      cmd.addr   = CMD_AW'(core_addr);
      cmd.wdata  = CMD_DW'(core_wdata);
      cmd.funct3 = core_funct3;
    end else begin
      cmd.we     = dma_we;
      cmd.addr   = CMD_AW'(dma_addr);
      cmd.wdata  = CMD_DW'(dma_wdata);
      cmd.funct3 = dma_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWN_DMA;
      wait_cnt   <= '0;
    end else begin
      if (core_gnt) begin
        state      <= CORE;
        last_owner <= OWN_CORE;
      end else if (dma_gnt) begin
        state      <= dma_lock ? DMA_LOCKED : DMA;
        last_owner <= OWN_DMA;
      end else begin
        state <= IDLE;
      end
      // Saturating starvation counter, live only while locked out
      if (state == DMA_LOCKED && core_req && !core_gnt)
        wait_cnt <= (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  dmem_arb_cmd_reg #(
    .AW(AW),
    .DW(DW)
  ) u_cmd_reg (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd        (cmd),
    .owner      (owner),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_core_beats <= '0;
      stat_dma_beats  <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (core_req && core_gnt) stat_core_beats <= stat_core_beats + 32'd1;
      if (dma_req && dma_gnt)   stat_dma_beats  <= stat_dma_beats + 32'd1;
      if (core_req && dma_req)  stat_conflicts  <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven arbitration vectors,
// hand-written multi-cycle sequences, and a load-return scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [2:0]    core_funct3 = '0;
  logic          core_gnt, core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic [2:0]    dma_funct3 = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   stat_core_beats, stat_dma_beats, stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_lock(dma_lock),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_core_beats(stat_core_beats), .stat_dma_beats(stat_dma_beats),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Memory: unwritten words read back a fixed address pattern
  function automatic logic [31:0] pattern(input logic [5:0] idx);
    return {24'hA50000, idx, 2'b00};
  endfunction

  logic [31:0] mem [0:63];
  logic [63:0] wr_flag;
  assign mem_rdata = wr_flag[mem_addr[7:2]] ? mem[mem_addr[7:2]] : pattern(mem_addr[7:2]);

  always @(posedge clk or negedge rst) begin
    if (!rst) wr_flag <= '0;
    else if (mem_write && mem_funct3 == F3_SW) begin
      mem[mem_addr[7:2]]     <= mem_wdata;
      wr_flag[mem_addr[7:2]] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected load data per owner, pushed on acceptance
  logic [31:0] cq[$];
  logic [31:0] dq[$];
  logic [31:0] shadow [0:63];
  logic [63:0] sh_flag;

  task automatic accept(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic is_core);
    logic [5:0] idx;
    idx = a[7:2];
    if (we) begin
      if (f == F3_SW) begin
        shadow[idx]  = d;
        sh_flag[idx] = 1'b1;
      end
    end else if (is_core) cq.push_back(sh_flag[idx] ? shadow[idx] : pattern(idx));
    else                  dq.push_back(sh_flag[idx] ? shadow[idx] : pattern(idx));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cq.delete();
      dq.delete();
      sh_flag = '0;
    end else begin
      if (core_rvalid) begin
        if (cq.size() == 0) chk("core_rvalid_unexpected", core_rvalid, 1'b0);
        else chk("core_rdata", core_rdata, cq.pop_front());
      end
      if (dma_rvalid) begin
        if (dq.size() == 0) chk("dma_rvalid_unexpected", dma_rvalid, 1'b0);
        else chk("dma_rdata", dma_rdata, dq.pop_front());
      end
      if (core_req && core_gnt) accept(core_we, core_addr, core_wdata, core_funct3, 1'b1);
      if (dma_req && dma_gnt)   accept(dma_we, dma_addr, dma_wdata, dma_funct3, 1'b0);
    end
  end

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_funct3 = F3_LW;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_funct3 = F3_LW;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 of cycle 0 with reset released
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic cr, dr, dl, ecg, edg;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 1, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0};

    // Reset values
    idle_inputs();
    #12;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_funct3", mem_funct3, 3'b000);
    chk("rst_core_rvalid", core_rvalid, 1'b0);
    chk("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk("rst_core_rdata", core_rdata, 32'h0);

    // Table-driven arbitration
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i != 0) next_cycle();
      core_req = tbl[i].cr; core_addr = 32'(i * 4);
      dma_req = tbl[i].dr; dma_lock = tbl[i].dl; dma_addr = 32'(32'h80 + i * 4);
      #1;
      chk($sformatf("tbl%0d_core_gnt", i), core_gnt, tbl[i].ecg);
      chk($sformatf("tbl%0d_dma_gnt", i), dma_gnt, tbl[i].edg);
      chk($sformatf("tbl%0d_core_stall", i), core_stall, tbl[i].cr & ~tbl[i].ecg);
`ifdef DMEM_ARB_STATS_EN
      if (i == 6) chk("stat_conflicts_6", stat_conflicts, 32'd6);
`endif
    end
    next_cycle(); idle_inputs();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 32'd7);
    chk("stat_core_beats", stat_core_beats, 32'd5);
    chk("stat_dma_beats", stat_dma_beats, 32'd6);
`endif
    repeat (3) next_cycle();

    // Core-only LW 0x10
    do_reset();
    core_req = 1'b1; core_addr = 32'h10; core_funct3 = F3_LW;
    #1 chk("lw_gnt", core_gnt, 1'b1); chk("lw_stall0", core_stall, 1'b0);
    next_cycle(); core_req = 1'b0;
    #1 chk("lw_mem_read", mem_read, 1'b1); chk("lw_mem_addr", mem_addr, 32'h10);
    chk("lw_mem_funct3", mem_funct3, F3_LW); chk("lw_stall1", core_stall, 1'b0);
    next_cycle();
    #1 chk("lw_rvalid", core_rvalid, 1'b1); chk("lw_rdata", core_rdata, pattern(6'h04));
    chk("lw_read_once", mem_read, 1'b0);
    next_cycle();
    #1 chk("lw_rvalid_once", core_rvalid, 1'b0);

    // DMA SW 0xDEADBEEF to 0x40, then core LW 0x40
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF; dma_funct3 = F3_SW;
    #1 chk("sw_dma_gnt", dma_gnt, 1'b1);
    next_cycle(); dma_req = 1'b0; core_req = 1'b1; core_addr = 32'h40; core_funct3 = F3_LW;
    #1 chk("sw_mem_write", mem_write, 1'b1); chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_mem_addr", mem_addr, 32'h40); chk("sw_core_gnt", core_gnt, 1'b1);
    next_cycle(); core_req = 1'b0;
    #1 chk("sw_write_once", mem_write, 1'b0); chk("sw_dma_no_rvalid", dma_rvalid, 1'b0);
    next_cycle();
    #1 chk("ld_rvalid", core_rvalid, 1'b1); chk("ld_rdata", core_rdata, 32'hDEADBEEF);
    idle_inputs();

    // Lock starvation: core waits MAX_WAIT cycles, then forced through
    do_reset();
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h80;
    #1 chk("lock_c0_dma_gnt", dma_gnt, 1'b1);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      next_cycle();
      core_req = 1'b1; core_addr = 32'h20; dma_addr = 32'(32'h80 + k * 4);
      #1 chk($sformatf("lock_c%0d_stall", k), core_stall, 1'b1);
      chk($sformatf("lock_c%0d_dma_gnt", k), dma_gnt, 1'b1);
    end
    next_cycle(); dma_addr = 32'hA4;
    #1 chk("lock_force_core_gnt", core_gnt, 1'b1); chk("lock_force_dma_gnt", dma_gnt, 1'b0);
    chk("lock_force_stall", core_stall, 1'b0);
    next_cycle(); core_req = 1'b0;
    #1 chk("lock_resume_dma_gnt", dma_gnt, 1'b1);
    next_cycle(); core_req = 1'b1; core_addr = 32'h24; dma_addr = 32'hA8;
    #1 chk("lock_relock_stall", core_stall, 1'b1); chk("lock_relock_dma", dma_gnt, 1'b1);
    next_cycle(); dma_req = 1'b0; dma_lock = 1'b0;
    #1 chk("lock_release_core_gnt", core_gnt, 1'b1);
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();

    // Reset in the cycle after a load grant
    do_reset();
    core_req = 1'b1; core_addr = 32'h30;
    #1 chk("rstmid_gnt", core_gnt, 1'b1);
    next_cycle(); core_req = 1'b0; rst = 1'b0;
    #1 chk("rstmid_mem_read", mem_read, 1'b0); chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_rvalid", core_rvalid, 1'b0);
    repeat (2) next_cycle();
    chk("rstmid_rvalid_later", core_rvalid, 1'b0); chk("rstmid_strobe_later", mem_read, 1'b0);
    rst = 1'b1; core_req = 1'b1; dma_req = 1'b1; core_addr = 32'h34; dma_addr = 32'h84;
    #1 chk("rstmid_core_first", core_gnt, 1'b1); chk("rstmid_dma_wait", dma_gnt, 1'b0);
    next_cycle(); core_req = 1'b0;
    #1 chk("rstmid_dma_next", dma_gnt, 1'b1);
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();

    // Core SB to 0x23
    do_reset();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h23; core_wdata = 32'h55; core_funct3 = F3_SB;
    #1 chk("sb_gnt", core_gnt, 1'b1);
    next_cycle(); core_req = 1'b0;
    #1 chk("sb_mem_write", mem_write, 1'b1); chk("sb_mem_funct3", mem_funct3, 3'b000);
    chk("sb_mem_addr", mem_addr, 32'h23); chk("sb_no_read", mem_read, 1'b0);
    next_cycle();
    #1 chk("sb_write_once", mem_write, 1'b0); chk("sb_no_rvalid", core_rvalid, 1'b0);
    repeat (3) next_cycle();

    chk("core_queue_drained", 64'(cq.size()), 64'd0);
    chk("dma_queue_drained", 64'(dq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
